vga_clut_banked: RTL

- Parametrised, multi-bank colour lookup table with one cycle-shared single-port memory.
- Serves two Wishbone-style slave ports:
  - pixel port: read-only, driven by the VGA controller's master interface;
  - host port: read/write, driven by the system bus.
- Generalises the fixed 24-bit x 512 CLUT:
  - configurable colour width and depth;
  - 2^BW palette banks with frame-synchronous bank swap;
  - round-robin arbitration;
  - byte-lane writes.

---
 rtl/vga_clut_pkg.sv | 14 +
 rtl/vga_clut_banked_if.sv | 44 ++++
 rtl/vga_clut_spram.sv | 30 +++
 rtl/vga_clut_banked.sv | 85 ++++++++
 4 files changed

// File: rtl/vga_clut_pkg.sv
// rtl/vga_clut_pkg.sv - shared types and helpers for the banked colour lookup table
package vga_clut_pkg;

  typedef enum logic [1:0] {
    NONE,
    PIX,
    HOST
  } owner_t;

  function automatic int lane_count(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/vga_clut_banked_if.sv
// rtl/vga_clut_banked_if.sv - pixel port, host port and bank-control signals of the CLUT
interface vga_clut_banked_if #(
  parameter int DW = 24,
  parameter int AW = 8,
  parameter int BW = 1
);
  logic [AW-1:0]    p_adr_i;
  logic             p_we_i;
  logic             p_stb_i;
  logic             p_cyc_i;
  logic [DW-1:0]    p_dat_o;
  logic             p_ack_o;
  logic             p_err_o;
  logic [BW+AW-1:0] h_adr_i;
  logic [DW-1:0]    h_dat_i;
  logic [DW-1:0]    h_dat_o;
  logic [DW/8-1:0]  h_sel_i;
  logic             h_we_i;
  logic             h_stb_i;
  logic             h_cyc_i;
  logic             h_ack_o;
  logic             h_err_o;
  logic [BW-1:0]    bank_sel_i;
  logic             swap_i;
  logic [BW-1:0]    active_bank_o;

  modport slave (
    input  p_adr_i, p_we_i, p_stb_i, p_cyc_i,
    output p_dat_o, p_ack_o, p_err_o,
    input  h_adr_i, h_dat_i, h_sel_i, h_we_i, h_stb_i, h_cyc_i,
    output h_dat_o, h_ack_o, h_err_o,
    input  bank_sel_i, swap_i,
    output active_bank_o
  );

  modport master (
    output p_adr_i, p_we_i, p_stb_i, p_cyc_i,
    input  p_dat_o, p_ack_o, p_err_o,
    output h_adr_i, h_dat_i, h_sel_i, h_we_i, h_stb_i, h_cyc_i,
    input  h_dat_o, h_ack_o, h_err_o,
    output bank_sel_i, swap_i,
    input  active_bank_o
  );
endinterface

// File: rtl/vga_clut_spram.sv
// rtl/vga_clut_spram.sv - single-port RAM with byte-lane write enables and registered read
module vga_clut_spram
  import vga_clut_pkg::*;
#(
  parameter int DW  = 24,
  parameter int NL  = 3,
  parameter int ADW = 9
) (
  input  logic           clk,
  input  logic           en,
  input  logic           we,
  input  logic [NL-1:0]  be,
  input  logic [ADW-1:0] adr,
  input  logic [DW-1:0]  wdat,
  output logic [DW-1:0]  rdat
);
  logic [DW-1:0] mem [2**ADW];

  // Read returns the entry as it was before this cycle's write.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int k = 0; k < NL; k++) begin
          if (be[k]) mem[adr][8*k +: 8] <= wdat[8*k +: 8];
        end
      end
      rdat <= mem[adr];
    end
  end
endmodule

// File: rtl/vga_clut_banked.sv
// rtl/vga_clut_banked.sv - banked CLUT: round-robin pixel/host arbitration over one RAM
module vga_clut_banked
  import vga_clut_pkg::*;
#(
  parameter int DW = 24,
  parameter int AW = 8,
  parameter int BW = 1
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  vga_clut_banked_if.slave bus
);
  localparam int NL = lane_count(DW);

  owner_t           last_q;
  owner_t           last_d;
  owner_t           grant;
  logic             p_ack;
  logic             h_ack;
  logic             p_err;
  logic             p_rd_req;
  logic             p_wr_req;
  logic             h_req;
  logic [BW-1:0]    active_bank;
  logic [BW+AW-1:0] mem_adr;
  logic             mem_en;
  logic             mem_we;
  logic [DW-1:0]    rdat;

  // A port is ineligible while its last response is on the bus, so a held stb is not served twice.
  assign p_rd_req = bus.p_cyc_i & bus.p_stb_i & ~bus.p_we_i & ~p_ack & ~p_err;
  assign p_wr_req = bus.p_cyc_i & bus.p_stb_i &  bus.p_we_i & ~p_ack & ~p_err;
  assign h_req    = bus.h_cyc_i & bus.h_stb_i & ~h_ack;

  always_comb begin
    grant  = NONE;
    last_d = last_q;
    if (p_rd_req && (!h_req || last_q != PIX)) grant = PIX;
    else if (h_req) grant = HOST;
    if (grant != NONE) last_d = grant;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      last_q      <= NONE;
      p_ack       <= 1'b0;
      h_ack       <= 1'b0;
      p_err       <= 1'b0;
      active_bank <= '0;
    end else begin
      last_q <= last_d;
      p_ack  <= (grant == PIX);
      h_ack  <= (grant == HOST);
      p_err  <= p_wr_req;
      if (bus.swap_i) active_bank <= bus.bank_sel_i;
    end
  end

  // The pixel address uses the bank in force during the grant cycle, before any swap lands.
  assign mem_en  = (grant != NONE) & ~wb_rst_i;
  assign mem_we  = (grant == HOST) & bus.h_we_i;
  assign mem_adr = (grant == HOST) ? bus.h_adr_i : {active_bank, bus.p_adr_i};

  vga_clut_spram #(
    .DW (DW),
    .NL (NL),
    .ADW(BW + AW)
  ) u_ram (
    .clk (wb_clk_i),
    .en  (mem_en),
    .we  (mem_we),
    .be  (bus.h_sel_i),
    .adr (mem_adr),
    .wdat(bus.h_dat_i),
    .rdat(rdat)
  );

  assign bus.p_dat_o       = p_ack ? rdat : '0;
  assign bus.h_dat_o       = h_ack ? rdat : '0;
  assign bus.p_ack_o       = p_ack;
  assign bus.h_ack_o       = h_ack;
  assign bus.p_err_o       = p_err;
  assign bus.h_err_o       = 1'b0;
  assign bus.active_bank_o = active_bank;
endmodule
